// File: rtl/my_if_pkg.sv
// Types and defaults shared by both ends of the my_if byte channel.
package my_if_pkg;

  typedef logic [7:0] data_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } mon_state_t;

  localparam int unsigned DEFAULT_DEPTH = 4;

endpackage

// File: rtl/my_if_sink_if.sv
// my_if valid/ready byte channel; master drives data/valid, slave drives ready.
interface my_if_sink_if;
  import my_if_pkg::*;

  data_t data;
  logic  valid;
  logic  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/my_if_sink_fifo.sv
// DEPTH-entry byte FIFO with separately tracked level and a look-ahead next_level.
module my_if_sink_fifo
  import my_if_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  data_t                    wdata,
  output data_t                    rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   next_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  data_t             mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic do_push;
  logic do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  assign rdata = mem[rd_ptr];
  assign valid = (level != '0);

  always_comb begin
    next_level = level;
    if (flush) begin
      next_level = '0;
    end else begin
      next_level = level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage is cleared on reset so the head read is never X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= next_level;
    end
  end

endmodule

// File: rtl/my_if_sink.sv
// my_if receiver: buffers accepted bytes, counts them, and flags stall-stability breaches.
module my_if_sink
  import my_if_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  my_if_sink_if.slave             up,
  my_if_sink_if.master            dn,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        accept_cnt,
  output logic                    proto_err
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              ready_q;
  logic              push;
  logic              pop;
  logic              head_valid;
  data_t             head_data;
  logic [LVL_W-1:0]  next_level;
  mon_state_t        mon_state;
  data_t             stall_data;

  assign up.ready = ready_q;
  assign dn.valid = head_valid;
  assign dn.data  = head_data;

  assign push = up.valid && ready_q;
  assign pop  = head_valid && dn.ready;

  my_if_sink_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .wdata      (up.data),
    .rdata      (head_data),
    .valid      (head_valid),
    .level      (level),
    .next_level (next_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q    <= 1'b0;
      accept_cnt <= '0;
    end else begin
      ready_q <= !flush && (next_level < LVL_W'(DEPTH));
      if (push && !flush) begin
        accept_cnt <= accept_cnt + CNT_W'(1);
      end
    end
  end

  // The breach check runs before the state update so a flush cycle is still checked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_state  <= IDLE;
      stall_data <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (mon_state == STALL && (!up.valid || up.data != stall_data)) begin
        proto_err <= 1'b1;
      end
      if (flush) begin
        mon_state <= IDLE;
      end else begin
        case (mon_state)
          IDLE: begin
            if (up.valid && !ready_q) begin
              mon_state  <= STALL;
              stall_data <= up.data;
            end
          end
          STALL: begin
            if (!up.valid || ready_q) begin
              mon_state <= IDLE;
            end
          end
          default: mon_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_my_if_sink.sv
// Randomised self-checking bench for my_if_sink against a queue-based reference model.
module tb_my_if_sink;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  level;
  logic [3:0]  accept_cnt;
  logic        proto_err;

  my_if_sink_if up_if ();
  my_if_sink_if dn_if ();

  my_if_sink #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .up         (up_if),
    .dn         (dn_if),
    .flush      (flush),
    .level      (level),
    .accept_cnt (accept_cnt),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic       m_ready;
  int         m_cnt;
  logic       m_err;
  logic       m_stall;
  logic [7:0] m_cap;

  function automatic void model_reset();
    mq.delete();
    m_ready = 1'b0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_stall = 1'b0;
    m_cap   = 8'h00;
  endfunction

  function automatic void model_edge();
    logic push_now;
    logic pop_now;
    push_now = up_if.valid && m_ready;
    pop_now  = (mq.size() != 0) && dn_if.ready;
    if (m_stall && (!up_if.valid || up_if.data != m_cap)) m_err = 1'b1;
    if (flush) m_stall = 1'b0;
    else if (m_stall) begin
      if (!up_if.valid || push_now) m_stall = 1'b0;
    end else if (up_if.valid && !m_ready) begin
      m_stall = 1'b1;
      m_cap   = up_if.data;
    end
    if (flush) mq.delete();
    else begin
      if (pop_now) void'(mq.pop_front());
      if (push_now) begin
        mq.push_back(up_if.data);
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
    end
    m_ready = !flush && (mq.size() < DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    up_if.valid = 1'b0;
    up_if.data = 8'h00;
    dn_if.ready = 1'b0;
    flush = 1'b0;
    model_reset();
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    repeat (DEPTH + 1) tick();
    dn_if.ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset(3);
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", up_if.ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", dn_if.valid); end
    checks++; if (dn_if.data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", dn_if.data); end
    checks++; if (accept_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", accept_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", proto_err); end
    tick();
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", up_if.ready); end
  endtask

  task automatic test_single();
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1;
    up_if.data = 8'hA5;
    tick();
    up_if.valid = 1'b0;
    checks++; if (dn_if.valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", dn_if.valid); end
    checks++; if (dn_if.data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", dn_if.data); end
    checks++; if (accept_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", accept_cnt); end
    tick();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_pop_level got=%0d exp=0", level); end
  endtask

  task automatic test_fill();
    logic [7:0] got[$];
    int cnt0;
    logic sent05;
    dn_if.ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      up_if.valid = 1'b1;
      up_if.data = 8'(i);
      tick();
      checks++; if (level !== 3'(i)) begin errors++; $display("FAIL fill_level got=%0d exp=%0d", level, i); end
    end
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", up_if.ready); end
    cnt0 = m_cnt;
    up_if.data = 8'h05;
    repeat (2) tick();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_hold_level got=%0d exp=4", level); end
    checks++; if (accept_cnt !== 4'(cnt0)) begin errors++; $display("FAIL full_hold_cnt got=%0d exp=%0d", accept_cnt, cnt0); end
    dn_if.ready = 1'b1;
    sent05 = 1'b0;
    for (int c = 0; c < 12 && got.size() < 5; c++) begin
      if (dn_if.valid) got.push_back(dn_if.data);
      sent05 = sent05 || (up_if.valid && m_ready);
      tick();
      if (sent05) up_if.valid = 1'b0;
    end
    up_if.valid = 1'b0;
    checks++; if (got.size() != 5) begin errors++; $display("FAIL drain_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      checks++; if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, got[i], 8'(i + 1)); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[$];
    logic [7:0] got[$];
    int cnt0;
    dn_if.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      up_if.valid = 1'b1;
      up_if.data = 8'($urandom);
      sent.push_back(up_if.data);
      tick();
    end
    cnt0 = m_cnt;
    dn_if.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_if.data = 8'($urandom);
      sent.push_back(up_if.data);
      if (dn_if.valid) got.push_back(dn_if.data);
      tick();
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level got=%0d exp=2", level); end
    end
    up_if.valid = 1'b0;
    checks++; if (accept_cnt !== 4'((cnt0 + 6) % 16)) begin errors++; $display("FAIL b2b_cnt got=%0d exp=%0d", accept_cnt, (cnt0 + 6) % 16); end
    for (int c = 0; c < 6; c++) begin
      if (dn_if.valid) got.push_back(dn_if.data);
      tick();
    end
    checks++; if (got.size() != sent.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got.size(), sent.size()); end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, got[i], sent[i]); end
    end
    dn_if.ready = 1'b0;
  endtask

  task automatic test_proto_err();
    dn_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_if.valid = 1'b1;
      up_if.data = 8'($urandom);
      tick();
    end
    up_if.data = 8'h10;
    tick();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL stall_no_err got=%b exp=0", proto_err); end
    up_if.data = 8'h11;
    tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_set got=%b exp=1", proto_err); end
    up_if.valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_sticky got=%b exp=1", proto_err); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL proto_flush_level got=%0d exp=0", level); end
    do_reset(2);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_err_reset got=%b exp=0", proto_err); end
    tick();
  endtask

  task automatic test_flush();
    int cnt0;
    dn_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_if.valid = 1'b1;
      up_if.data = 8'($urandom);
      tick();
    end
    cnt0 = m_cnt;
    up_if.data = 8'($urandom);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    up_if.valid = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", dn_if.valid); end
    checks++; if (accept_cnt !== 4'(cnt0)) begin errors++; $display("FAIL flush_cnt got=%0d exp=%0d", accept_cnt, cnt0); end
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low got=%b exp=0", up_if.ready); end
    tick();
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL flush_ready_back got=%b exp=1", up_if.ready); end
  endtask

  task automatic test_wrap();
    do_reset(2);
    tick();
    dn_if.ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      up_if.valid = 1'b1;
      up_if.data = 8'($urandom);
      tick();
    end
    up_if.valid = 1'b0;
    tick();
    checks++; if (accept_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt got=%0d exp=1", accept_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wrap_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int c = 0; c < 400; c++) begin
      if (m_stall && up_if.valid && ($urandom_range(0, 49) != 0)) begin
        // keep the stalled byte stable most of the time
      end else begin
        up_if.valid = ($urandom_range(0, 3) != 0);
        up_if.data = 8'($urandom);
      end
      dn_if.ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      tick();
      checks++; if (up_if.ready !== m_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, up_if.ready, m_ready); end
      checks++; if (level !== 3'(mq.size())) begin errors++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", c, level, mq.size()); end
      checks++; if (dn_if.valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, dn_if.valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (dn_if.data !== mq[0]) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, dn_if.data, mq[0]); end
      end
      checks++; if (accept_cnt !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, accept_cnt, m_cnt); end
      checks++; if (proto_err !== m_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, proto_err, m_err); end
    end
    flush = 1'b0;
    up_if.valid = 1'b0;
  endtask

  initial begin
    up_if.valid = 1'b0;
    up_if.data = 8'h00;
    dn_if.ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_proto_err();
    test_flush();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/my_if_sink.md
Name: my_if_sink

Overview:
- Receiver for the my_if valid/ready byte channel; drives the AccessOut side (consumes data and valid, produces ready).
- Buffers accepted bytes in a small FIFO and re-presents them on a downstream valid/ready port.
- Counts accepted bytes and flags upstream protocol violations (stall-stability breaches) with a sticky error.
- Sits between any AccessIn-side producer and local consumer logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the accepted-byte counter.

Ports:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- if_data  input  8  channel data (my_if.data).
- if_valid  input  1  channel valid (my_if.valid).
- if_ready  output  1  channel ready (my_if.ready).
- flush  input  1  synchronous FIFO clear.
- out_data  output  8  head-of-FIFO byte.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accept.
- level  output  $clog2(DEPTH)+1  current occupancy.
- accept_cnt  output  CNT_W  accepted bytes, wraps modulo 2^CNT_W.
- proto_err  output  1  sticky upstream protocol violation.

Behaviour:
- Reset, asynchronous on reset_n low: FIFO empty, level=0, out_valid=0, out_data=0, if_ready=0, accept_cnt=0, proto_err=0. All state is released on the first clk edge after reset_n rises.
- if_ready: registered, equal to (next level < DEPTH) and not flush. It is 0 while in reset and goes to 1 on the first edge after reset release.
- Push: occurs on an edge where if_valid and if_ready are both 1. if_data is written at the tail and accept_cnt increments by 1.
- Pop: occurs on an edge where out_valid and out_ready are both 1. The head advances.
- Latency: a byte pushed at edge N is visible on out_data/out_valid after edge N. There is no combinational path from if_* to out_*.
- out_data: combinational read of the head entry. Its value is don't-care when out_valid=0, but it must not be X after reset.
- Simultaneous push and pop: both happen and level is unchanged. This is legal when full only if if_ready was already 1, which it cannot be, so a full FIFO never accepts a push.
- Full: level==DEPTH, so if_ready=0. Empty: out_valid=0 and out_ready is ignored.
- Pointers: log2(DEPTH) bits, wrapping naturally. level is tracked separately.
- Upstream monitor FSM:
  - States: IDLE, STALL.
  - IDLE -> STALL when if_valid=1 and if_ready=0 on an edge. The stalled if_data is captured at that edge.
  - STALL -> IDLE when the push completes (if_valid and if_ready).
  - In STALL, if if_valid drops, or if_data differs from the captured value, proto_err is set to 1. It stays 1 until reset; flush does not clear it.
  - In STALL, an if_valid drop also returns the FSM to IDLE.
- flush, applied on an edge:
  - level becomes 0, pointers reset, out_valid becomes 0.
  - Any push or pop in that same cycle is discarded; accept_cnt is not incremented for a push discarded by flush.
  - if_ready is 0 for the cycle after flush.
  - The monitor FSM returns to IDLE.
- accept_cnt: counts every push (not discarded by flush) and wraps from all-ones to 0 without error.
- Reset mid-transfer: everything clears immediately. A byte in flight is lost; this is acceptable.

Decomposition:
- Shared package my_if_pkg:
  - typedef of the 8-bit data type, shared by both channel ends.
  - Monitor-state enum (IDLE, STALL).
  - Default DEPTH constant.
- Sub-module my_if_sink_fifo (storage, pointers, level; DEPTH-parameterised).
  - Keeps the storage reusable for the matching transmit-side skid buffer.
  - The top level holds the handshake, counter and monitor.

Test Plan:
- Reset, then single byte: reset_n low for 3 cycles, then push 8'hA5 with out_ready=1.
  - if_ready=1 one cycle after release.
  - out_data=8'hA5 with out_valid=1 on the next cycle.
  - accept_cnt=1.
- Fill to full: out_ready=0, push 8'h01..8'h04 back to back (DEPTH=4).
  - if_ready drops after the 4th push; level=4.
  - Holding if_valid with 8'h05 is not accepted.
  - out_ready=1 then drains 01,02,03,04 in order, then 05.
- Simultaneous push/pop: level=2, if_valid and out_ready both held for 6 cycles.
  - level stays 2.
  - Output order matches input order.
  - accept_cnt rises by 6.
- Protocol error: level=4, if_valid=1 with 8'h10, data changed to 8'h11 while stalled.
  - proto_err=1 one cycle later.
  - proto_err remains 1 through a subsequent flush; only reset_n clears it.
- Flush with concurrent push: level=3, flush=1 while if_valid=1.
  - level=0 and out_valid=0 next cycle.
  - accept_cnt unchanged.
  - if_ready=0 for one cycle, then 1.
- Counter wrap: CNT_W=4, push 17 bytes.
  - accept_cnt=1.
  - No proto_err.
